// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: Moore strobes decoded from the registered state.
// Define LEGV8_ILLEGAL_TRAP_EN to send unrecognised opcodes to HALT instead of a no-op.
module legv8_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg2loc,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        halted,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,  S_ADDR   = 4'd5,  S_MEM_RD = 4'd6,  S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,  S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [1:0] CL_NONE = 2'd0, CL_CBZ = 2'd1, CL_CBNZ = 2'd2, CL_STUR = 2'd3;

  state_t     state_q;
  state_t     dec_d;
  logic [1:0] cls_q, cls_d;

  logic is_jump, is_cbz, is_cbnz, is_addi, is_ldur, is_stur, is_rtype, is_halt;

  assign is_jump  = (opcode[10:5] == 6'b000101);
  assign is_cbz   = (opcode[10:3] == 8'b10110100);
  assign is_cbnz  = (opcode[10:3] == 8'b10110101);
  assign is_addi  = (opcode[10:1] == 10'b1001000100);
  assign is_ldur  = (opcode == 11'b11111000010);
  assign is_stur  = (opcode == 11'b11111000000);
  assign is_rtype = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                    (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
  assign is_halt  = (opcode == 11'b11111111111);

  always_comb begin
    if (is_jump)                 dec_d = S_JUMP;
    else if (is_cbz || is_cbnz)  dec_d = S_BRANCH;
    else if (is_addi)            dec_d = S_EXEC_I;
    else if (is_ldur || is_stur) dec_d = S_ADDR;
    else if (is_rtype)           dec_d = S_EXEC_R;
    else if (is_halt)            dec_d = S_HALT;
`ifdef LEGV8_ILLEGAL_TRAP_EN
    else                         dec_d = S_HALT;
`else
    else                         dec_d = S_FETCH;
`endif
  end

  // Only the branch/store flavour must outlive DECODE; the IR holds the rest.
  always_comb begin
    cls_d = CL_NONE;
    if (is_jump)      cls_d = CL_NONE;
    else if (is_cbz)  cls_d = CL_CBZ;
    else if (is_cbnz) cls_d = CL_CBNZ;
    else if (is_stur) cls_d = CL_STUR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_START;
      cls_q   <= CL_NONE;
    end else begin
      case (state_q)
        S_START:  state_q <= S_FETCH;
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          state_q <= dec_d;
          cls_q   <= cls_d;
        end
        S_EXEC_R, S_EXEC_I: state_q <= S_WB_ALU;
        S_ADDR:   state_q <= (cls_q == CL_STUR) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: if (mem_ready) state_q <= S_WB_MEM;
        S_MEM_WR: if (mem_ready) state_q <= S_FETCH;
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_START;
      endcase
    end
  end

  logic taken;
  assign taken = ((cls_q == CL_CBZ) && zero) || ((cls_q == CL_CBNZ) && !zero);

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: reg2loc = is_stur || is_cbz || is_cbnz;
      S_EXEC_R: alu_op  = 2'b10;
      S_EXEC_I: alu_src = 1'b1;
      S_WB_ALU: reg_write = 1'b1;
      S_ADDR: begin
        alu_src = 1'b1;
        reg2loc = (cls_q == CL_STUR);
      end
      S_MEM_RD: mem_read = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        reg2loc   = 1'b1;
      end
      S_BRANCH: begin
        reg2loc  = 1'b1;
        alu_op   = 2'b01;
        pc_write = taken;
        pc_src   = taken;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench: directed per-cycle vectors push expected {state,strobes}; a negedge monitor pops and compares.
module tb_legv8_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, pc_src, mem_read, mem_write, reg2loc, alu_src;
  logic [1:0]  alu_op;
  logic        reg_write, mem_to_reg, halted;
  logic [3:0]  state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  legv8_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted), .state(state)
  );

  // Strobe word: {ir_write,pc_write,pc_src,mem_read,mem_write,reg2loc,alu_src,alu_op[1:0],reg_write,mem_to_reg,halted}
  localparam logic [11:0] O_NONE = 12'b000000000000;
  localparam logic [11:0] O_FWT  = 12'b000100000000;
  localparam logic [11:0] O_FRDY = 12'b110100000000;
  localparam logic [11:0] O_DR2L = 12'b000001000000;
  localparam logic [11:0] O_EXR  = 12'b000000010000;
  localparam logic [11:0] O_EXI  = 12'b000000100000;
  localparam logic [11:0] O_WBA  = 12'b000000000100;
  localparam logic [11:0] O_ADLD = 12'b000000100000;
  localparam logic [11:0] O_ADST = 12'b000001100000;
  localparam logic [11:0] O_MRD  = 12'b000100000000;
  localparam logic [11:0] O_WBM  = 12'b000000000110;
  localparam logic [11:0] O_MWR  = 12'b000011000000;
  localparam logic [11:0] O_BTK  = 12'b011001001000;
  localparam logic [11:0] O_BNT  = 12'b000001001000;
  localparam logic [11:0] O_JMP  = 12'b011000000000;
  localparam logic [11:0] O_HLT  = 12'b000000000001;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_HLT  = 11'b11111111111;
  localparam logic [10:0] OP_ILL  = 11'b00000000000;

  task automatic step(input logic r, input logic [10:0] op, input logic z, input logic mr,
                      input logic [3:0] es, input logic [11:0] eo);
    @(posedge clk); #1;
    rst_n = r; opcode = op; zero = z; mem_ready = mr;
    exp_q.push_back({es, eo});
  endtask

  always @(negedge clk) begin
    logic [15:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {state, ir_write, pc_write, pc_src, mem_read, mem_write, reg2loc, alu_src,
           alu_op, reg_write, mem_to_reg, halted};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle%0d state/strobes: got state=%0d outs=%b, exp state=%0d outs=%b",
                 cyc, a[15:12], a[11:0], e[15:12], e[11:0]);
      end
      checks++;
      if ((mem_read && mem_write) || (reg_write && pc_write)) begin
        failures++;
        $display("FAIL cycle%0d exclusivity: mem_read=%b mem_write=%b reg_write=%b pc_write=%b, exp no pair high",
                 cyc, mem_read, mem_write, reg_write, pc_write);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, exp run complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then START for one cycle after release
    step(0, OP_ADD, 0, 0, 4'd0, O_NONE);
    step(0, OP_ADD, 0, 0, 4'd0, O_NONE);
    step(1, OP_ADD, 0, 1, 4'd0, O_NONE);
    // ADD: 1,2,3,8
    step(1, OP_ADD, 0, 1, 4'd1, O_FRDY);
    step(1, OP_ADD, 0, 1, 4'd2, O_NONE);
    step(1, OP_ADD, 0, 1, 4'd3, O_EXR);
    step(1, OP_ADD, 0, 1, 4'd8, O_WBA);
    // ADDI with one fetch wait cycle
    step(1, OP_ADDI, 0, 0, 4'd1, O_FWT);
    step(1, OP_ADDI, 0, 1, 4'd1, O_FRDY);
    step(1, OP_ADDI, 0, 1, 4'd2, O_NONE);
    step(1, OP_ADDI, 0, 1, 4'd4, O_EXI);
    step(1, OP_ADDI, 0, 1, 4'd8, O_WBA);
    // LDUR with 3 wait cycles in MEM_RD: 8 cycles total
    step(1, OP_LDUR, 0, 1, 4'd1, O_FRDY);
    step(1, OP_LDUR, 0, 1, 4'd2, O_NONE);
    step(1, OP_LDUR, 0, 0, 4'd5, O_ADLD);
    for (int i = 0; i < 3; i++) step(1, OP_LDUR, 0, 0, 4'd6, O_MRD);
    step(1, OP_LDUR, 0, 1, 4'd6, O_MRD);
    step(1, OP_LDUR, 0, 1, 4'd9, O_WBM);
    // STUR, no wait
    step(1, OP_STUR, 0, 1, 4'd1, O_FRDY);
    step(1, OP_STUR, 0, 1, 4'd2, O_DR2L);
    step(1, OP_STUR, 0, 1, 4'd5, O_ADST);
    step(1, OP_STUR, 0, 1, 4'd7, O_MWR);
    // CBZ zero=1 taken
    step(1, OP_CBZ, 0, 1, 4'd1, O_FRDY);
    step(1, OP_CBZ, 0, 1, 4'd2, O_DR2L);
    step(1, OP_CBZ, 1, 1, 4'd10, O_BTK);
    // CBNZ zero=1 not taken
    step(1, OP_CBNZ, 0, 1, 4'd1, O_FRDY);
    step(1, OP_CBNZ, 0, 1, 4'd2, O_DR2L);
    step(1, OP_CBNZ, 1, 1, 4'd10, O_BNT);
    // CBNZ zero=0 taken
    step(1, OP_CBNZ, 0, 1, 4'd1, O_FRDY);
    step(1, OP_CBNZ, 0, 1, 4'd2, O_DR2L);
    step(1, OP_CBNZ, 0, 1, 4'd10, O_BTK);
    // CBZ zero=0 not taken
    step(1, OP_CBZ, 0, 1, 4'd1, O_FRDY);
    step(1, OP_CBZ, 0, 1, 4'd2, O_DR2L);
    step(1, OP_CBZ, 0, 1, 4'd10, O_BNT);
    // B: JUMP in cycle 3
    step(1, OP_B, 0, 1, 4'd1, O_FRDY);
    step(1, OP_B, 0, 1, 4'd2, O_NONE);
    step(1, OP_B, 0, 1, 4'd11, O_JMP);
    // Unrecognised opcode
    step(1, OP_ILL, 0, 1, 4'd1, O_FRDY);
    step(1, OP_ILL, 0, 1, 4'd2, O_NONE);
`ifdef LEGV8_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) step(1, OP_ILL, 0, 1, 4'd12, O_HLT);
    step(0, OP_ILL, 0, 1, 4'd0, O_NONE);
    step(1, OP_ILL, 0, 1, 4'd0, O_NONE);
`endif
    // STUR stalled in MEM_WR, then asynchronous reset
    step(1, OP_STUR, 0, 1, 4'd1, O_FRDY);
    step(1, OP_STUR, 0, 1, 4'd2, O_DR2L);
    step(1, OP_STUR, 0, 0, 4'd5, O_ADST);
    step(1, OP_STUR, 0, 0, 4'd7, O_MWR);
    step(0, OP_STUR, 0, 0, 4'd0, O_NONE);
    step(0, OP_STUR, 0, 0, 4'd0, O_NONE);
    step(1, OP_HLT, 0, 1, 4'd0, O_NONE);
    step(1, OP_HLT, 0, 1, 4'd1, O_FRDY);
    // HALT persists regardless of inputs
    step(1, OP_HLT, 0, 1, 4'd2, O_NONE);
    for (int i = 0; i < 100; i++)
      step(1, (i % 2 == 0) ? OP_ADD : OP_HLT, i[0], i[1], 4'd12, O_HLT);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/legv8_multicycle_ctrl.md
# legv8_multicycle_ctrl

Multicycle control unit for the LEGv8 subset core: LDUR, STUR, ADD, ADDI, SUB, AND, ORR, CBZ, CBNZ, B and HALT. It sequences one shared ALU, one unified instruction/data memory port and the register file across fetch, decode, execute, memory and writeback states. The block consumes the opcode field and the ALU zero flag. It emits per-state Moore control strobes, with a ready handshake to variable-latency memory.

## Interface
- (no parameters)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  11  instruction[31:21] from instruction register
- zero  in  1  ALU zero flag, valid in BRANCH state
- mem_ready  in  1  memory completes current access this cycle
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = PC + (sign-extended offset << 2)
- mem_read  out  1  memory read request (held until mem_ready)
- mem_write  out  1  memory write request (held until mem_ready)
- reg2loc  out  1  1 = read register Rt (STUR, CBZ, CBNZ)
- alu_src  out  1  1 = immediate operand from sign extension
- alu_op  out  2  00 add, 01 pass-B (compare), 10 funct-decoded
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  1 = writeback data from memory data register
- halted  out  1  core stopped
- state  out  4  current state encoding, for debug

## Operation
- States and encodings: START 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, ADDR 5, MEM_RD 6, MEM_WR 7, WB_ALU 8, WB_MEM 9, BRANCH 10, JUMP 11, HALT 12. Encodings 13–15 are unreachable and go to START.
- Decode priority in DECODE:
  - opcode[10:5]=000101 → JUMP.
  - opcode[10:3]=10110100 (CBZ) or 10110101 (CBNZ) → BRANCH.
  - opcode[10:1]=1001000100 → EXEC_I.
  - LDUR 11111000010 or STUR 11111000000 → ADDR.
  - ADD/SUB/AND/ORR (10001011000, 11001011000, 10001010000, 10101010000) → EXEC_R.
  - 11111111111 → HALT.
  - Anything else → see Configuration.
- START: all outputs 0 → FETCH.
- FETCH: mem_read=1. Stays while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=0 in that same cycle → DECODE.
- DECODE: reg2loc=1 if opcode is STUR/CBZ/CBNZ; all other strobes 0.
- EXEC_R: alu_op=10 → WB_ALU.
- EXEC_I: alu_src=1, alu_op=00 → WB_ALU.
- WB_ALU: reg_write=1 → FETCH.
- ADDR: alu_src=1, alu_op=00, reg2loc=1 for STUR → MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: mem_read=1. Waits for mem_ready → WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1 → FETCH.
- MEM_WR: mem_write=1, reg2loc=1. Waits for mem_ready → FETCH.
- BRANCH: reg2loc=1, alu_op=01. pc_write=1 and pc_src=1 when (CBZ and zero=1) or (CBNZ and zero=0) → FETCH.
- JUMP: pc_write=1, pc_src=1 → FETCH.
- HALT: halted=1, all other strobes 0. Terminal until reset.
- Opcode is sampled combinationally from the IR. The IR is stable after FETCH, so no internal opcode register is needed beyond a 2-bit class latch (CBZ/CBNZ/STUR) captured in DECODE.

## Timing
- All outputs are decoded from the registered state (plus mem_ready for ir_write/pc_write in FETCH, and zero in BRANCH). No output is registered separately.
- Reset assertion immediately forces state=START and every output to 0, including halted. Reset mid-access drops mem_read/mem_write asynchronously.
- Cycles per instruction with mem_ready=1 on first request:
  - R/ADDI: 4 (FETCH, DECODE, EXEC, WB).
  - LDUR: 5.
  - STUR: 4.
  - CBZ/CBNZ/B: 3.
- Each memory wait cycle adds 1. mem_read/mem_write are held constant while waiting.
- mem_read and mem_write are never high together. reg_write and pc_write are never high together.

## Configuration
- LEGV8_ILLEGAL_TRAP_EN defined: an unrecognised opcode in DECODE → HALT (halted=1).
- Not defined: an unrecognised opcode is a no-op. DECODE → FETCH with no register or memory side effect, and the PC already advanced.

## Test plan
- Reset mid-MEM_WR: rst_n low while mem_write=1 → mem_write drops immediately, state=0. After release, START for one cycle, then FETCH with mem_read=1.
- ADD 0x8B020020 with mem_ready tied 1 → state sequence 1,2,3,8,1. reg_write high exactly 1 cycle. alu_op=10 in EXEC_R.
- LDUR with mem_ready low for 3 cycles in MEM_RD → mem_read held 4 cycles, then WB_MEM with reg_write=1, mem_to_reg=1. Total 8 cycles.
- CBZ with zero=1 → pc_write=1, pc_src=1 in BRANCH. CBNZ with zero=1 → pc_write=0. Both return to FETCH.
- B 0x14000003 → JUMP in cycle 3 with pc_src=1. Next FETCH begins on cycle 4.
- HALT 0xFFE00000 → halted=1 persists for 100 cycles. Opcode 0x000 gives HALT with LEGV8_ILLEGAL_TRAP_EN defined, and a return to FETCH without it.
